// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding and width defaults for the memory arbiter
package mem_arb_pkg;

    localparam int AW_DEFAULT = 32;
    localparam int DW_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INST = 2'd1,
        DATA = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arb_ibuf.sv
// rtl/mem_arb_ibuf.sv - one-entry fetch buffer {valid, addr, word}, used only under MEM_ARB_IBUF_EN
module mem_arb_ibuf
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fill_en,
    input  logic [AW-1:0] fill_addr,
    input  logic [DW-1:0] fill_word,
    input  logic          clr,
    input  logic [AW-1:0] lookup_addr,
    output logic          hit,
    output logic [DW-1:0] word
);

    logic          valid_q, valid_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] word_q, word_d;

    assign hit  = valid_q & (addr_q == lookup_addr);
    assign word = word_q;

    // Refill on every completed fetch; a completed store may alias the entry, so drop it.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        word_d  = word_q;
        if (fill_en) begin
            valid_d = 1'b1;
            addr_d  = fill_addr;
            word_d  = fill_word;
        end else if (clr) begin
            valid_d = 1'b0;
        end
    end

    // Buffer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            word_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data to single memory bus arbiter with pipeline stall; fetch buffer under MEM_ARB_IBUF_EN
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inst_req,
    input  logic [AW-1:0] inst_addr,
    output logic [DW-1:0] inst_rdata,
    input  logic          data_req,
    input  logic          data_we,
    input  logic [AW-1:0] data_addr,
    input  logic [DW-1:0] data_wdata,
    output logic [DW-1:0] data_rdata,
    output logic          stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    arb_state_t    state_q, state_d;
    logic          inst_done_q, inst_done_d;
    logic          data_done_q, data_done_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] inst_rdata_q, inst_rdata_d;
    logic [DW-1:0] data_rdata_q, data_rdata_d;

    logic          inst_stall;
    logic          data_stall;
    logic          ibuf_hit;
    logic [DW-1:0] ibuf_word;

    // Stall depends only on requests and registered done flags, never on mem_ready.
    assign inst_stall = inst_req & ~inst_done_q;
    assign data_stall = data_req & ~data_done_q;
    assign stall      = inst_stall | data_stall;

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;

`ifdef MEM_ARB_IBUF_EN
    logic ibuf_fill;
    logic ibuf_clr;

    assign ibuf_fill = (state_q == INST) & mem_ready;
    assign ibuf_clr  = (state_q == DATA) & mem_ready & mem_we_q;

    mem_arb_ibuf #(
        .AW (AW),
        .DW (DW)
    ) u_ibuf (
        .clk         (clk),
        .rst         (rst),
        .fill_en     (ibuf_fill),
        .fill_addr   (mem_addr_q),
        .fill_word   (mem_rdata),
        .clr         (ibuf_clr),
        .lookup_addr (inst_addr),
        .hit         (ibuf_hit),
        .word        (ibuf_word)
    );
`else
    assign ibuf_hit  = 1'b0;
    assign ibuf_word = '0;
`endif

    // Grant and completion: data wins in IDLE (older instruction), bus fields latched at grant.
    always_comb begin
        state_d      = state_q;
        inst_done_d  = inst_done_q;
        data_done_d  = data_done_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;

        // Pipeline advances this edge: both ports start a fresh instruction.
        if (!stall) begin
            inst_done_d = 1'b0;
            data_done_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (data_stall) begin
                    state_d     = DATA;
                    mem_req_d   = 1'b1;
                    mem_we_d    = data_we;
                    mem_addr_d  = data_addr;
                    mem_wdata_d = data_wdata;
                end else if (inst_stall) begin
                    if (ibuf_hit) begin
                        inst_done_d  = 1'b1;
                        inst_rdata_d = ibuf_word;
                    end else begin
                        state_d     = INST;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = inst_addr;
                        mem_wdata_d = '0;
                    end
                end
            end
            INST: begin
                if (mem_ready) begin
                    state_d      = IDLE;
                    mem_req_d    = 1'b0;
                    inst_rdata_d = mem_rdata;
                    inst_done_d  = 1'b1;
                end
            end
            DATA: begin
                if (mem_ready) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    data_done_d = 1'b1;
                    if (!mem_we_q) begin
                        data_rdata_d = mem_rdata;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Arbiter state, bus registers and held read data; reset abandons any transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            inst_done_q  <= 1'b0;
            data_done_q  <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            inst_done_q  <= inst_done_d;
            data_done_q  <= data_done_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

endmodule
